// File: rtl/itch_msg_framer.sv
// ITCH message framer: decodes the type byte of word 0, tags each forwarded word with
// its index and a per-type start level, checks length, and counts completed messages.
module itch_msg_framer #(
  parameter int unsigned FIRST_IDX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inValid,
  input  logic [63:0] inData,
  input  logic        inLast,
  output logic        outValid,
  output logic [63:0] outData,
  output logic [3:0]  outCounter,
  output logic        startAddOrderNoMPID,
  output logic        startOrderExecuted,
  output logic        startOrderDelete,
  output logic        startTime,
  output logic        msgDone,
  output logic        lenErr,
  output logic        unkType,
  output logic [15:0] msgCount
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 16;
  localparam logic [IDX_W-1:0] IDX_SAT = IDX_W'(15 - FIRST_IDX);
  localparam logic [7:0] TYPE_A = 8'h41;
  localparam logic [7:0] TYPE_E = 8'h45;
  localparam logic [7:0] TYPE_D = 8'h44;
  localparam logic [7:0] TYPE_T = 8'h54;

  typedef enum logic [1:0] {IDLE, BODY, DRAIN} state_t;

  state_t           state, state_nx;
  logic [7:0]       typ, typ_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [7:0]       cur_typ;
  logic [IDX_W-1:0] cur_len;
  logic [IDX_W-1:0] word_idx;
  logic             known;
  logic             fwd, done, lerr, unk;

  // Expected message length in words; zero marks an unknown type.
  function automatic logic [IDX_W-1:0] len_of(input logic [7:0] t);
    case (t)
      TYPE_A:  len_of = IDX_W'(5);
      TYPE_E:  len_of = IDX_W'(3);
      TYPE_D:  len_of = IDX_W'(2);
      TYPE_T:  len_of = IDX_W'(1);
      default: len_of = '0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      typ   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      typ   <= typ_nx;
      idx   <= idx_nx;
    end
  end

  // Next-state and per-word decisions; word 0 decodes straight from the input byte.
  always_comb begin
    state_nx = state;
    typ_nx   = typ;
    idx_nx   = idx;
    fwd      = 1'b0;
    done     = 1'b0;
    lerr     = 1'b0;
    unk      = 1'b0;
    cur_typ  = (state == IDLE) ? inData[7:0] : typ;
    cur_len  = len_of(cur_typ);
    known    = (cur_len != '0);
    word_idx = (state == IDLE) ? '0 : idx;
    if (inValid) begin
      case (state)
        IDLE: begin
          typ_nx = inData[7:0];
          fwd    = 1'b1;
          unk    = !known;
          if (inLast) begin
            done   = 1'b1;
            lerr   = known && (cur_len > IDX_W'(1));
            idx_nx = '0;
          end else begin
            state_nx = BODY;
            idx_nx   = IDX_W'(1);
          end
        end
        BODY: begin
          if (known && (idx == cur_len)) begin
            lerr     = 1'b1;
            done     = inLast;
            state_nx = inLast ? IDLE : DRAIN;
            idx_nx   = inLast ? '0 : idx;
          end else begin
            fwd = 1'b1;
            if (inLast) begin
              done     = 1'b1;
              lerr     = known && ((idx + IDX_W'(1)) < cur_len);
              state_nx = IDLE;
              idx_nx   = '0;
            end else if (known || (idx != IDX_SAT)) begin
              idx_nx = idx + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (inLast) begin
            done     = 1'b1;
            state_nx = IDLE;
            idx_nx   = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output register stage; data and counter hold when nothing is forwarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid            <= 1'b0;
      outData             <= '0;
      outCounter          <= '0;
      startAddOrderNoMPID <= 1'b0;
      startOrderExecuted  <= 1'b0;
      startOrderDelete    <= 1'b0;
      startTime           <= 1'b0;
      msgDone             <= 1'b0;
      lenErr              <= 1'b0;
      unkType             <= 1'b0;
      msgCount            <= '0;
    end else begin
      outValid            <= fwd;
      startAddOrderNoMPID <= fwd && (cur_typ == TYPE_A);
      startOrderExecuted  <= fwd && (cur_typ == TYPE_E);
      startOrderDelete    <= fwd && (cur_typ == TYPE_D);
      startTime           <= fwd && (cur_typ == TYPE_T);
      msgDone             <= done;
      lenErr              <= lerr;
      unkType             <= unk;
      if (fwd) begin
        outData    <= inData;
        outCounter <= IDX_W'(FIRST_IDX) + word_idx;
      end
      if (inValid && inLast) msgCount <= msgCount + CNT_W'(1);
    end
  end

endmodule

// File: doc/itch_msg_framer.md
# itch_msg_framer

Front-end framing stage for the ITCH feed path. It accepts a continuous 64-bit word stream with end-of-message marks and decodes the message type from the first word. Each word is forwarded with a per-message word index and a per-type start level, which the downstream field parsers (add-order, executed, delete, time) qualify on. It also checks message length against the per-type expectation and counts completed messages.

## Interface
- FIRST_IDX, 8, index value presented on `outCounter` for word 0 of a message (downstream parsers key on 8..12).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- inValid  in  1  input word valid. No backpressure: every valid word is consumed.
- inData  in  64  input word. In the first word of a message, `[7:0]` is the ASCII type.
- inLast  in  1  qualifies `inValid`; this word ends the message.
- outValid  out  1  forwarded word valid.
- outData  out  64  forwarded word, unmodified.
- outCounter  out  4  FIRST_IDX + word index within the message.
- startAddOrderNoMPID  out  1  current message type is 'A' (0x41).
- startOrderExecuted  out  1  current message type is 'E' (0x45).
- startOrderDelete  out  1  current message type is 'D' (0x44).
- startTime  out  1  current message type is 'T' (0x54).
- msgDone  out  1  one-cycle pulse, aligned with the output of the `inLast` word.
- lenErr  out  1  one-cycle pulse on a length violation.
- unkType  out  1  one-cycle pulse on the first word of an unknown type.
- msgCount  out  16  completed-message count; wraps at 0xFFFF to 0.

## Operation
- Expected lengths in words: A=5, E=3, D=2, T=1. Unknown types have no length check.
- FSM states: IDLE (next word is word 0), BODY (inside a message), DRAIN (overlong message; discard until last).
- IDLE, valid word:
  - Latch the type and set the start level for that type.
  - Forward the word with index 0.
  - If `inLast` is set: `msgDone`, stay in IDLE. Otherwise go to BODY with word index 1.
- BODY, valid word:
  - If index < expected length: forward the word.
  - If index == expected length (word overflows the message): assert `lenErr`, do not forward (`outValid`=0), go to DRAIN. If `inLast` is on this same word, go to IDLE instead.
  - On `inLast`: `msgDone`. If index+1 < expected, also assert `lenErr` (short message). Return to IDLE.
- DRAIN: words are not forwarded. On `inLast`: `msgDone`, return to IDLE.
- Unknown type:
  - Words are forwarded with all start levels 0 and `unkType` set on word 0.
  - The word index saturates at 15−FIRST_IDX.
  - The message never enters DRAIN.
- Start levels are asserted exactly when `outValid`=1 for a known-type message; otherwise they are 0.
- `msgCount` increments by 1 on every `inLast` word, in any state.
- `inValid`=0 cycles hold the FSM and index. All outputs for that cycle are `outValid`=0, pulses 0, start levels 0. `outData` and `outCounter` hold their last values.

## Timing
- All outputs are registered. Latency from input word to output is exactly 1 cycle.
- `msgDone`, `lenErr` and `unkType` are single-cycle pulses, aligned with the output cycle of the triggering input word.
- Back-to-back messages are supported with no gap: the word after an `inLast` word is word 0.
- Reset:
  - Values: every output becomes 0, `msgCount`=0, FSM=IDLE, index=0.
  - Reset mid-message aborts the message. No `msgDone` is produced.
  - The first valid word after reset deasserts is treated as word 0.
- Throughput: one word per cycle, sustained.

## Test plan
- Add order, 5 words, first word 0x…41, `inLast` on word 4:
  - Outputs one cycle later, `outCounter` = 8,9,10,11,12.
  - `startAddOrderNoMPID`=1 on all five words.
  - `msgDone` on word 12; `msgCount`=1.
- 'T' (1 word, `inLast`) immediately followed by 'D' (2 words):
  - `msgDone` on both `inLast` words.
  - `startTime` on one word, then `startOrderDelete` on two words, `outCounter` restarting at 8.
  - `msgCount`=2.
- 'E' sent with 5 words:
  - Words 0-2 forwarded.
  - `lenErr` pulse with word 3 and `outValid`=0 for words 3-4.
  - `msgDone` on word 4; the next message decodes normally.
- 'A' with `inLast` on word 2: `lenErr` and `msgDone` in the same cycle; FSM returns to IDLE.
- Type 0x5A, 3 words:
  - `unkType` pulse on word 0.
  - All start levels 0; words forwarded with `outCounter` 8,9,10; no `lenErr`.
- Other counter and reset cases:
  - `rst` during word 2 of an 'A': all outputs 0 next cycle, and the next word decodes as word 0.
  - Preload `msgCount` to 0xFFFF via 65535 single-word messages; the next `inLast` wraps it to 0.
  - `inValid` gaps inside a message do not advance `outCounter`.
